// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end. The unit issues word-aligned fetch addresses to an in-order,
// variable-latency instruction memory. It tags every request with its PC in a small in-order
// queue and stores the returned instructions in a registered FIFO. Decode drains that FIFO over
// a valid/ready handshake.
//
// Branch redirects flush the FIFO and mark all in-flight responses as stale so they are dropped
// when they return. A halt request, or a redirect to a misaligned target, stops fetch. The unit
// then waits for every outstanding response to come back and finally parks in a sticky halted
// state that only reset can leave.
//
// Ports
//   clk             clock; all state updates on the rising edge
//   reset           asynchronous, active-high reset
//   stall           suppress new requests this cycle (responses, pops, redirect, halt unaffected)
//   halt_req        stop fetching and drain outstanding responses
//   redirect_valid  taken branch: flush and refetch from redirect_pc
//   redirect_pc     redirect target
//   imem_req_valid  request valid towards instruction memory
//   imem_req_ready  memory accepts the request
//   imem_req_addr   request address (equals pc)
//   imem_resp_valid response valid; responses return in request order
//   imem_resp_data  returned instruction word
//   out_valid       head of the instruction FIFO is valid
//   out_ready       decode accepts the head instruction
//   out_instr       head instruction
//   out_pc          PC of the head instruction
//   pc              next fetch address
//   halted          sticky: fetch has stopped and all responses have drained
//   fetch_fault     sticky: a misaligned redirect target was seen
// ---------------------------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned       ADDR_W  = 64,
    parameter int unsigned       INSTR_W = 32,
    parameter int unsigned       DEPTH   = 4,
    parameter logic [ADDR_W-1:0] INIT_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               halt_req,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic               fetch_fault
);

    localparam int unsigned     PW        = $clog2(DEPTH);
    localparam int unsigned     CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_EXT = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       outst_q, outst_d;
    logic [CW-1:0]       drop_q, drop_d;
    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [PW-1:0]       tag_wr_q, tag_wr_d;
    logic [PW-1:0]       tag_rd_q, tag_rd_d;
    logic                halted_q, halted_d;
    logic                fault_q, fault_d;

    // Instruction FIFO and the in-order queue of request PCs.
    logic [INSTR_W-1:0]  buf_instr [DEPTH];
    logic [ADDR_W-1:0]   buf_pc    [DEPTH];
    logic [ADDR_W-1:0]   tag_pc    [DEPTH];

    logic                req_valid;
    logic                req_fire;
    logic                resp;
    logic                pop;
    logic                push;
    logic [CW:0]         credit_used;
    logic                misaligned;

    // A FIFO slot is reserved for every in-flight request, so responses can always be stored.
    assign credit_used = {1'b0, outst_q} + {1'b0, count_q};
    assign misaligned  = redirect_pc[1:0] != 2'b00;

    assign req_valid = !reset && (state_q == StRun) && !stall && !redirect_valid && !halt_req &&
                       (credit_used < DEPTH_EXT);
    assign req_fire  = req_valid && imem_req_ready;
    assign resp      = imem_resp_valid;
    assign pop       = (count_q != '0) && out_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        head_d   = head_q;
        tail_d   = tail_q;
        drop_d   = drop_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        push     = 1'b0;
        outst_d  = outst_q + CW'(req_fire) - CW'(resp);
        tag_wr_d = req_fire ? tag_wr_q + PW'(1) : tag_wr_q;
        tag_rd_d = resp ? tag_rd_q + PW'(1) : tag_rd_q;

        if (req_fire) begin
            pc_d = pc_q + ADDR_W'(4);
        end

        unique case (state_q)
            StRun: begin
                if (halt_req || (redirect_valid && misaligned)) begin
                    // Stop fetching; anything still in flight is discarded on return.
                    if (!halt_req) begin
                        fault_d = 1'b1;
                    end
                    count_d = '0;
                    head_d  = '0;
                    tail_d  = '0;
                    drop_d  = '0;
                    if (outst_d == '0) begin
                        state_d  = StHalted;
                        halted_d = 1'b1;
                    end else begin
                        state_d  = StDrain;
                    end
                end else if (redirect_valid) begin
                    // Every request still in flight after this edge belongs to the old path.
                    // That includes a response arriving this cycle, which is also not stored.
                    count_d = '0;
                    head_d  = '0;
                    tail_d  = '0;
                    drop_d  = outst_d;
                    pc_d    = redirect_pc;
                end else begin
                    if (resp) begin
                        if (drop_q != '0) begin
                            drop_d = drop_q - CW'(1);
                        end else begin
                            push = 1'b1;
                        end
                    end
                    if (push) begin
                        tail_d = tail_q + PW'(1);
                    end
                    if (pop) begin
                        head_d = head_q + PW'(1);
                    end
                    count_d = count_q + CW'(push) - CW'(pop);
                end
            end
            StDrain: begin
                if (outst_d == '0) begin
                    state_d  = StHalted;
                    halted_d = 1'b1;
                end
            end
            StHalted: begin
            end
            default: begin
                state_d = StHalted;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StRun;
            pc_q     <= INIT_PC;
            count_q  <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    // Storage arrays need no reset: the counters and pointers qualify every read.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_pc[tag_wr_q] <= pc_q;
        end
        if (push) begin
            buf_instr[tail_q] <= imem_resp_data;
            buf_pc[tail_q]    <= tag_pc[tag_rd_q];
        end
    end

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_q;
    assign out_valid      = count_q != '0;
    assign out_instr      = out_valid ? buf_instr[head_q] : '0;
    assign out_pc         = out_valid ? buf_pc[head_q] : '0;
    assign pc             = pc_q;
    assign halted         = halted_q;
    assign fetch_fault    = fault_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ({1'b0, count_q} <= DEPTH_EXT)
                else $error("fetch_unit: buffer count above DEPTH");
            assert ({1'b0, outst_q} <= DEPTH_EXT)
                else $error("fetch_unit: outstanding above DEPTH");
            assert ({1'b0, drop_q} <= DEPTH_EXT)
                else $error("fetch_unit: drop count above DEPTH");
            assert (!(imem_resp_valid && outst_q == '0))
                else $error("fetch_unit: response with nothing outstanding");
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. It models an in-order instruction memory with a configurable
// fixed latency. Instructions are a fixed function of their address. Two instances are used:
// one with INIT_PC=0 and one whose INIT_PC sits just below the wrap point.
// ---------------------------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [63:0] INIT2 = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk;
    logic        reset;
    logic        stall, halt_req, redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid, out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc, pc;
    logic        halted, fetch_fault;

    logic        stall2, halt_req2, redirect_valid2;
    logic [63:0] redirect_pc2;
    logic        imem_req_valid2, imem_req_ready2;
    logic [63:0] imem_req_addr2;
    logic        imem_resp_valid2;
    logic [31:0] imem_resp_data2;
    logic        out_valid2, out_ready2;
    logic [31:0] out_instr2;
    logic [63:0] out_pc2, pc2;
    logic        halted2, fetch_fault2;

    fetch_unit #(.ADDR_W(64), .INSTR_W(32), .DEPTH(4), .INIT_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .pc(pc), .halted(halted),
        .fetch_fault(fetch_fault)
    );

    fetch_unit #(.ADDR_W(64), .INSTR_W(32), .DEPTH(4), .INIT_PC(INIT2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall2), .halt_req(halt_req2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .imem_req_valid(imem_req_valid2), .imem_req_ready(imem_req_ready2),
        .imem_req_addr(imem_req_addr2), .imem_resp_valid(imem_resp_valid2),
        .imem_resp_data(imem_resp_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_instr(out_instr2), .out_pc(out_pc2), .pc(pc2), .halted(halted2),
        .fetch_fault(fetch_fault2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          due;
        logic [63:0] addr;
    } req_t;

    req_t        pend[$];
    logic [63:0] issued[$];
    logic [63:0] pop_pc[$];
    logic [31:0] pop_instr[$];
    int          cyc;
    int          lat;
    int          n_assert;
    int          n_fail;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample handshakes before the edge, then run the memory model after it.
    task automatic tick();
        logic        fire;
        logic        popped;
        logic [63:0] a;
        #1;
        fire   = imem_req_valid && imem_req_ready;
        a      = imem_req_addr;
        popped = out_valid && out_ready;
        if (popped) begin
            pop_pc.push_back(out_pc);
            pop_instr.push_back(out_instr);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (fire) begin
            issued.push_back(a);
            pend.push_back('{cyc + lat, a});
        end
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (pend.size() > 0 && pend[0].due == cyc + 1) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_of(pend[0].addr);
            void'(pend.pop_front());
        end
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        pend.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        issued.delete();
        pop_pc.delete();
        pop_instr.delete();
    endtask

    initial begin
        n_assert = 0; n_fail = 0; cyc = 0; lat = 1;
        reset = 1'b1;
        stall = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0; out_ready = 1'b1;
        stall2 = 1'b0; halt_req2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = '0;
        imem_req_ready2 = 1'b1; imem_resp_valid2 = 1'b0; imem_resp_data2 = '0;
        out_ready2 = 1'b0;

        // Reset state
        #1;
        chk("rst_pc", pc, 64'h0);
        chk("rst_req_valid", {63'b0, imem_req_valid}, 64'h0);
        chk("rst_out_valid", {63'b0, out_valid}, 64'h0);
        chk("rst_out_instr", {32'b0, out_instr}, 64'h0);
        chk("rst_out_pc", out_pc, 64'h0);
        chk("rst_halted", {63'b0, halted}, 64'h0);
        chk("rst_fault", {63'b0, fetch_fault}, 64'h0);
        chk("rst_pc2", pc2, INIT2);

        // 1: latency 1, streaming at one instruction per cycle
        lat = 1;
        do_reset();
        repeat (12) tick();
        chk("t1_issued_cnt", 64'(issued.size()), 64'd12);
        chk("t1_popped_cnt", 64'(pop_pc.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            chk("t1_addr", issued[i], 64'(4 * i));
            chk("t1_out_pc", pop_pc[i], 64'(4 * i));
            chk("t1_out_instr", {32'b0, pop_instr[i]}, {32'b0, instr_of(64'(4 * i))});
        end
        stall = 1'b1;
        #1;
        chk("t1_stall_blocks", {63'b0, imem_req_valid}, 64'h0);
        stall = 1'b0;

        // 2: back-pressure fills buffer, then release
        lat = 2;
        out_ready = 1'b0;
        do_reset();
        repeat (20) tick();
        #1;
        chk("t2_req_valid_low", {63'b0, imem_req_valid}, 64'h0);
        chk("t2_issued_cnt", 64'(issued.size()), 64'd4);
        chk("t2_out_valid", {63'b0, out_valid}, 64'h1);
        chk("t2_head_pc", out_pc, 64'h0);
        out_ready = 1'b1;
        repeat (30) tick();
        chk("t2_popped_enough", {63'b0, pop_pc.size() >= 20}, 64'h1);
        for (int i = 0; i < pop_pc.size(); i++) begin
            chk("t2_out_pc", pop_pc[i], 64'(4 * i));
            chk("t2_out_instr", {32'b0, pop_instr[i]}, {32'b0, instr_of(64'(4 * i))});
        end

        // 3: aligned redirect with two requests in flight
        lat = 3;
        do_reset();
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t3_pc", pc, 64'h100);
        chk("t3_no_pop_yet", 64'(pop_pc.size()), 64'd0);
        repeat (10) tick();
        chk("t3_first_pc", pop_pc[0], 64'h100);
        chk("t3_first_instr", {32'b0, pop_instr[0]}, {32'b0, instr_of(64'h100)});
        chk("t3_second_pc", pop_pc[1], 64'h104);

        // 4: misaligned redirect
        lat = 3;
        do_reset();
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h102;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t4_fault", {63'b0, fetch_fault}, 64'h1);
        chk("t4_req_valid", {63'b0, imem_req_valid}, 64'h0);
        chk("t4_pc", pc, 64'h8);
        chk("t4_halted_early", {63'b0, halted}, 64'h0);
        tick();
        chk("t4_halted_one_left", {63'b0, halted}, 64'h0);
        tick();
        chk("t4_halted", {63'b0, halted}, 64'h1);
        repeat (2) tick();
        chk("t4_issued_cnt", 64'(issued.size()), 64'd2);
        chk("t4_pc_final", pc, 64'h8);
        chk("t4_out_valid", {63'b0, out_valid}, 64'h0);

        // 5: halt with three requests in flight
        lat = 3;
        do_reset();
        repeat (3) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        #1;
        chk("t5_req_valid", {63'b0, imem_req_valid}, 64'h0);
        chk("t5_out_valid", {63'b0, out_valid}, 64'h0);
        chk("t5_halted_early", {63'b0, halted}, 64'h0);
        tick();
        chk("t5_halted_mid", {63'b0, halted}, 64'h0);
        tick();
        chk("t5_halted", {63'b0, halted}, 64'h1);
        chk("t5_issued_cnt", 64'(issued.size()), 64'd3);
        chk("t5_fault", {63'b0, fetch_fault}, 64'h0);

        // 6: PC wrap and asynchronous reset mid-fetch
        do_reset();
        #1;
        chk("t6_addr0", imem_req_addr2, INIT2);
        chk("t6_req_valid", {63'b0, imem_req_valid2}, 64'h1);
        tick();
        #1;
        chk("t6_addr1_wrap", imem_req_addr2, 64'h0);
        imem_resp_valid2 = 1'b1;
        imem_resp_data2  = 32'hCAFE_F00D;
        tick();
        imem_resp_valid2 = 1'b0;
        #1;
        chk("t6_out_valid", {63'b0, out_valid2}, 64'h1);
        chk("t6_out_pc", out_pc2, INIT2);
        chk("t6_out_instr", {32'b0, out_instr2}, 64'hCAFE_F00D);
        chk("t6_pc", pc2, 64'h4);
        reset = 1'b1;
        #1;
        chk("t6_rst_pc", pc2, INIT2);
        chk("t6_rst_out_valid", {63'b0, out_valid2}, 64'h0);
        chk("t6_rst_req_valid", {63'b0, imem_req_valid2}, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
